// File: rtl/dcache1_victim_wbq_if.sv
// L2 victim write-back handshake bundle.
//   out_req  : request to L2, out_addr valid
//   out_addr : address of the victim line at the queue head
//   out_ack  : L2 accepted the head entry
//   out_nack : L2 refused the head entry; requester backs off and retries
// master = queue side (drives req/addr), slave = L2 side (drives ack/nack).
interface dcache1_victim_wbq_if #(
  parameter int ADDR_WIDTH = 37
);
  logic                  out_req;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_ack;
  logic                  out_nack;

  modport master (
    output out_req,
    output out_addr,
    input  out_ack,
    input  out_nack
  );

  modport slave (
    input  out_req,
    input  out_addr,
    output out_ack,
    output out_nack
  );
endinterface

// File: rtl/dcache1_victim_wbq.sv
// Victim write-back queue for dcache1.
// Captures displaced valid lines reported by dcache1_tag during a fill and
// issues them in order to L2 with a req/ack/nack handshake. A nack parks the
// head for RETRY_DLY cycles before it is requested again. Pending entries,
// including the in-flight head, can be probed so loads and snoops can stall.
// All state updates on negedge clk to line up with the tag arrays.
//
// Ports:
//   clk, rst    : clock (negedge active), synchronous active-high reset
//   vict_en     : fill cycle, vict_addr/vict_valid meaningful
//   vict_addr   : displaced line address (wb_addr)
//   vict_valid  : displaced line was valid (wb_valid)
//   vict_stall  : queue full, fill must be held this cycle
//   l2          : L2 handshake (out_req/out_addr out, out_ack/out_nack in)
//   chk_addr    : probe address
//   chk_hit     : probe matches an occupied entry
//   count/empty : occupancy
module dcache1_victim_wbq #(
  parameter int ADDR_WIDTH = 37,
  parameter int DEPTH      = 8,
  parameter int RETRY_DLY  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vict_en,
  input  logic [ADDR_WIDTH-1:0]          vict_addr,
  input  logic                           vict_valid,
  output logic                           vict_stall,
  dcache1_victim_wbq_if.master           l2,
  input  logic [ADDR_WIDTH-1:0]          chk_addr,
  output logic                           chk_hit,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (RETRY_DLY > 1) ? $clog2(RETRY_DLY) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] BACKOFF = 2'd2;

  logic [ADDR_WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0]      occ;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [BW-1:0]         bcnt;
  logic [BW-1:0]         bcnt_next;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  // Stall looks only at current occupancy; a same-cycle pop does not open a slot.
  assign vict_stall = full;
  assign push       = vict_en & vict_valid & ~full;
  assign pop        = (state == REQ) & l2.out_ack;

  assign l2.out_req  = (state == REQ);
  assign l2.out_addr = (state == REQ) ? entry[rptr] : '0;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
  end

  // ack has priority over nack; both are ignored outside REQ.
  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    case (state)
      IDLE: begin
        if (!empty)
          state_next = REQ;
      end
      REQ: begin
        if (l2.out_ack) begin
          state_next = (count_next != '0) ? REQ : IDLE;
        end else if (l2.out_nack) begin
          state_next = BACKOFF;
          bcnt_next  = BW'(RETRY_DLY - 1);
        end
      end
      BACKOFF: begin
        if (bcnt == '0)
          state_next = REQ;
        else
          bcnt_next = bcnt - BW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-entry occupancy bits let the probe compare every slot in parallel
  // without decoding the rptr..wptr range.
  always_comb begin
    chk_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ[i] && (entry[i] == chk_addr))
        chk_hit = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      occ   <= '0;
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      count <= count_next;
      if (pop) begin
        occ[rptr] <= 1'b0;
        rptr      <= rptr + PW'(1);
      end
      if (push) begin
        occ[wptr]   <= 1'b1;
        entry[wptr] <= vict_addr;
        wptr        <= wptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache1_victim_wbq.sv
module tb_dcache1_victim_wbq;

  localparam int AW    = 37;
  localparam int DEPTH = 8;
  localparam int RD    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          vict_en;
  logic [AW-1:0] vict_addr;
  logic          vict_valid;
  logic          vict_stall;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic [CW-1:0] count;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  // reference model: ordered list of pending victims plus request/backoff status
  logic [AW-1:0] mq[$];
  bit            m_act;
  int            m_bo;

  dcache1_victim_wbq_if #(.ADDR_WIDTH(AW)) bus ();

  dcache1_victim_wbq #(
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .RETRY_DLY(RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vict_en(vict_en),
    .vict_addr(vict_addr),
    .vict_valid(vict_valid),
    .vict_stall(vict_stall),
    .l2(bus),
    .chk_addr(chk_addr),
    .chk_hit(chk_hit),
    .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance one active (negedge) clock, updating the model from the driven
  // inputs, and return in the quiet window after the following posedge.
  task automatic tick();
    int pre;
    bit was;
    @(negedge clk);
    if (rst) begin
      mq.delete();
      m_act = 0;
      m_bo  = 0;
    end else begin
      pre = mq.size();
      was = m_act;
      if (was && bus.out_ack) void'(mq.pop_front());
      if (vict_en && vict_valid && pre < DEPTH) mq.push_back(vict_addr);
      if (was) begin
        if (bus.out_ack) m_act = (mq.size() > 0);
        else if (bus.out_nack) begin
          m_act = 0;
          m_bo  = RD;
        end
      end else if (m_bo > 0) begin
        m_bo--;
        if (m_bo == 0) m_act = 1;
      end else if (pre > 0) begin
        m_act = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vict_en = 0; vict_valid = 0; vict_addr = '0;
    bus.out_ack = 0; bus.out_nack = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_addr = '0; #1;
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.out_req); end
    checks++; if (bus.out_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.out_addr); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (vict_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", vict_stall); end
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL reset_chk got=%b exp=0", chk_hit); end
  endtask

  task automatic test_single();
    logic [AW-1:0] a = 37'h1_2345_6781;
    vict_en = 1; vict_valid = 1; vict_addr = a;
    tick();
    idle_inputs(); #1;
    checks++; if (bus.out_req !== 1'b0 || count !== CW'(1)) begin failures++; $display("FAIL single_lat req=%b cnt=%0d exp req=0 cnt=1", bus.out_req, count); end
    tick();
    checks++; if (bus.out_req !== 1'b1 || bus.out_addr !== a) begin failures++; $display("FAIL single_req req=%b addr=%h exp 1 %h", bus.out_req, bus.out_addr, a); end
    bus.out_ack = 1;
    tick();
    bus.out_ack = 0; #1;
    checks++; if (empty !== 1'b1 || bus.out_req !== 1'b0 || bus.out_addr !== '0) begin failures++; $display("FAIL single_ack empty=%b req=%b addr=%h exp 1 0 0", empty, bus.out_req, bus.out_addr); end
  endtask

  task automatic test_no_valid();
    for (int i = 0; i < 4; i++) begin
      vict_en = 1; vict_valid = 0; vict_addr = {$urandom, $urandom} ;
      tick();
    end
    vict_en = 0; vict_valid = 1; vict_addr = 'x;
    tick();
    idle_inputs(); tick();
    checks++; if (count !== '0 || bus.out_req !== 1'b0) begin failures++; $display("FAIL no_valid cnt=%0d req=%b exp 0 0", count, bus.out_req); end
  endtask

  task automatic test_full();
    logic [AW-1:0] base = 37'h0_0ABC_0001;
    for (int i = 0; i < DEPTH; i++) begin
      vict_en = 1; vict_valid = 1; vict_addr = base + AW'(2 * i);
      tick();
    end
    vict_addr = base + AW'(2 * DEPTH); #1;
    checks++; if (count !== CW'(DEPTH) || vict_stall !== 1'b1) begin failures++; $display("FAIL full_cnt cnt=%0d stall=%b exp 8 1", count, vict_stall); end
    tick();
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_drop cnt=%0d exp 8", count); end
    vict_addr = base + AW'(2 * DEPTH + 2); bus.out_ack = 1; #1;
    checks++; if (vict_stall !== 1'b1) begin failures++; $display("FAIL full_stall_pop stall=%b exp 1", vict_stall); end
    tick();
    vict_en = 0; vict_valid = 0; #1;
    checks++; if (count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL full_popcnt cnt=%0d exp 7", count); end
    for (int i = 1; i < DEPTH; i++) begin
      #1;
      checks++; if (bus.out_req !== 1'b1 || bus.out_addr !== base + AW'(2 * i)) begin failures++; $display("FAIL full_drain%0d req=%b addr=%h exp %h", i, bus.out_req, bus.out_addr, base + AW'(2 * i)); end
      tick();
    end
    bus.out_ack = 0; #1;
    checks++; if (empty !== 1'b1 || bus.out_req !== 1'b0) begin failures++; $display("FAIL full_end empty=%b req=%b exp 1 0", empty, bus.out_req); end
  endtask

  task automatic test_nack();
    logic [AW-1:0] a = 37'h1_0000_0011;
    logic [AW-1:0] b = 37'h0_F0F0_F0F1;
    vict_en = 1; vict_valid = 1; vict_addr = a; tick();
    vict_addr = b; tick();
    idle_inputs(); #1;
    checks++; if (bus.out_req !== 1'b1 || bus.out_addr !== a) begin failures++; $display("FAIL nack_pre req=%b addr=%h exp 1 %h", bus.out_req, bus.out_addr, a); end
    bus.out_nack = 1; tick(); bus.out_nack = 0;
    for (int k = 0; k < RD; k++) begin
      bus.out_ack = (k == 1); #1;
      checks++; if (bus.out_req !== 1'b0 || bus.out_addr !== '0) begin failures++; $display("FAIL nack_low%0d req=%b addr=%h exp 0 0", k, bus.out_req, bus.out_addr); end
      tick();
    end
    bus.out_ack = 0; #1;
    checks++; if (bus.out_req !== 1'b1 || bus.out_addr !== a || count !== CW'(2)) begin failures++; $display("FAIL nack_retry req=%b addr=%h cnt=%0d exp 1 %h 2", bus.out_req, bus.out_addr, count, a); end
    bus.out_ack = 1; bus.out_nack = 1; tick();
    bus.out_nack = 0; bus.out_ack = 0; #1;
    checks++; if (bus.out_req !== 1'b1 || bus.out_addr !== b || count !== CW'(1)) begin failures++; $display("FAIL nack_ackwins req=%b addr=%h cnt=%0d exp 1 %h 1", bus.out_req, bus.out_addr, count, b); end
    bus.out_ack = 1; tick(); bus.out_ack = 0;
  endtask

  task automatic test_chk();
    logic [AW-1:0] a = 37'h0_1357_9BDF;
    logic [AW-1:0] b = 37'h1_2468_ACE1;
    vict_en = 1; vict_valid = 1; vict_addr = a; tick();
    vict_addr = b; chk_addr = b; #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL chk_samecycle got=%b exp 0", chk_hit); end
    tick();
    idle_inputs(); #1;
    checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL chk_b got=%b exp 1", chk_hit); end
    chk_addr = a; bus.out_ack = 1; #1;
    checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL chk_a_inflight got=%b exp 1", chk_hit); end
    tick();
    bus.out_ack = 0; #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL chk_a_acked got=%b exp 0", chk_hit); end
    chk_addr = b ^ AW'(2); #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL chk_nearmiss got=%b exp 0", chk_hit); end
    bus.out_ack = 1; tick(); bus.out_ack = 0;
  endtask

  task automatic test_rst_mid();
    logic [AW-1:0] a = 37'h0_0000_7771;
    for (int i = 0; i < 3; i++) begin
      vict_en = 1; vict_valid = 1; vict_addr = a + AW'(2 * i); tick();
    end
    idle_inputs(); chk_addr = a; #1;
    checks++; if (bus.out_req !== 1'b1 || count !== CW'(3)) begin failures++; $display("FAIL rstmid_pre req=%b cnt=%0d exp 1 3", bus.out_req, count); end
    rst = 1; tick(); rst = 0; #1;
    checks++; if (bus.out_req !== 1'b0 || count !== '0 || chk_hit !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rstmid req=%b cnt=%0d hit=%b empty=%b exp 0 0 0 1", bus.out_req, count, chk_hit, empty); end
    tick(); tick();
    checks++; if (bus.out_req !== 1'b0) begin failures++; $display("FAIL rstmid_idle req=%b exp 0", bus.out_req); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] base = 37'h1_FFFF_FF01;
    int pushed = 0;
    int acked  = 0;
    int budget = 200;
    while (acked < 20 && budget > 0) begin
      budget--;
      vict_en = (pushed < 20); vict_valid = 1; vict_addr = base + AW'(2 * pushed);
      bus.out_ack = bus.out_req; #1;
      if (bus.out_req === 1'b1) begin
        checks++; if (bus.out_addr !== base + AW'(2 * acked)) begin failures++; $display("FAIL wrap_order%0d got=%h exp=%h", acked, bus.out_addr, base + AW'(2 * acked)); end
        acked++;
      end
      if (vict_en) pushed++;
      tick();
    end
    idle_inputs();
    checks++; if (acked != 20) begin failures++; $display("FAIL wrap_timeout acked=%0d exp=20", acked); end
    tick(); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp 1", empty); end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [6];
    bit exp_hit;
    logic [AW-1:0] exp_addr;
    for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom} | AW'(1);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      vict_en    = ($urandom_range(0, 3) != 0);
      vict_valid = ($urandom_range(0, 3) != 0);
      vict_addr  = pool[$urandom_range(0, 5)];
      bus.out_ack  = ($urandom_range(0, 2) == 0);
      bus.out_nack = ($urandom_range(0, 3) == 0);
      chk_addr   = pool[$urandom_range(0, 5)];
      #1;
      exp_hit = 0;
      foreach (mq[i]) if (mq[i] == chk_addr) exp_hit = 1;
      exp_addr = m_act ? mq[0] : '0;
      checks++;
      if (bus.out_req !== m_act || bus.out_addr !== exp_addr || count !== CW'(mq.size()) ||
          empty !== (mq.size() == 0) || vict_stall !== (mq.size() == DEPTH) || chk_hit !== exp_hit) begin
        failures++;
        $display("FAIL rand%0d req=%b addr=%h cnt=%0d empty=%b stall=%b hit=%b exp %b %h %0d %b %b %b",
                 c, bus.out_req, bus.out_addr, count, empty, vict_stall, chk_hit,
                 m_act, exp_addr, mq.size(), mq.size() == 0, mq.size() == DEPTH, exp_hit);
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    rst = 1; idle_inputs(); chk_addr = '0;
    m_act = 0; m_bo = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_no_valid();
    test_full();
    test_nack();
    test_chk();
    test_rst_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
